// File: rtl/cpu_datapath_regs.sv
// Register/datapath stage behind the CPU controller: PC, IR, AC, halt latch,
// free-running 8-phase counter, memory bus drive and status back to the controller.
module cpu_datapath_regs #(
  parameter int AW = 5,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_,
  input  logic          mem_rd,
  input  logic          load_ir,
  input  logic          halt,
  input  logic          inc_pc,
  input  logic          load_ac,
  input  logic          load_pc,
  input  logic          mem_wr,
  input  logic [DW-1:0] mem_rdata,
  input  logic [DW-1:0] alu_out,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_re,
  output logic          mem_we,
  output logic [2:0]    opcode,
  output logic [AW-1:0] ir_addr,
  output logic [AW-1:0] pc,
  output logic [DW-1:0] ac,
  output logic          zero,
  output logic          fetch,
  output logic          halted,
  output logic          bus_err
);

  logic [2:0]    r_phase;
  logic [AW-1:0] r_pc;
  logic [DW-1:0] r_ir;
  logic [DW-1:0] r_ac;
  logic          r_halted;
  logic          r_bus_err;

  logic          w_fetch;
  logic          w_active;
  logic [AW-1:0] w_ir_addr;
  logic          w_bus_fault;

  assign w_fetch     = (r_phase < 3'd4);
  assign w_active    = ~r_halted;
  assign w_ir_addr   = r_ir[AW-1:0];
  // A write may only land in the operand half of the cycle; a read/write
  // collision or an early write is a controller fault worth latching.
  assign w_bus_fault = mem_wr & (mem_rd | w_fetch);

  // Phase keeps running while halted so it stays locked to the controller.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_phase <= 3'd0;
    end else begin
      r_phase <= r_phase + 3'd1;
    end
  end

  // load_pc wins over inc_pc and uses the pre-edge IR operand.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_pc <= '0;
    end else if (w_active) begin
      if (load_pc) begin
        r_pc <= w_ir_addr;
      end else if (inc_pc) begin
        r_pc <= r_pc + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_ir <= '0;
    end else if (w_active && load_ir) begin
      r_ir <= mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_ac <= '0;
    end else if (w_active && load_ac) begin
      r_ac <= alu_out;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_halted <= 1'b0;
    end else if (halt) begin
      r_halted <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_bus_err <= 1'b0;
    end else if (w_bus_fault) begin
      r_bus_err <= 1'b1;
    end
  end

  assign mem_addr  = w_fetch ? r_pc : w_ir_addr;
  assign mem_wdata = r_ac;
  assign mem_re    = mem_rd & w_active;
  assign mem_we    = mem_wr & w_active & ~w_fetch;
  assign opcode    = r_ir[DW-1:AW];
  assign ir_addr   = w_ir_addr;
  assign pc        = r_pc;
  assign ac        = r_ac;
  assign zero      = (r_ac == '0);
  assign fetch     = w_fetch;
  assign halted    = r_halted;
  assign bus_err   = r_bus_err;

endmodule
